// File: rtl/max_pool_stream_if.sv
// Stream handshake bundle for max_pool_stream: raster samples in, pooled maxima out.
// The master side is the producer/consumer environment; the slave side is the pooling block.
interface max_pool_stream_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, frame_done
  );
endinterface

// File: rtl/max_pool_stream.sv
// KxK / stride-K signed max pooling over a raster-order sample stream, one output register.
// Optional macro MAX_POOL_RELU_EN clamps negative pooled maxima to zero.
module max_pool_stream #(
  parameter int DATA_W = 16,
  parameter int K      = 2,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  max_pool_stream_if.slave   bus
);

  localparam int NWIN = IMG_W / K;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(NWIN - 1);

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  function automatic sample_t finalize(input sample_t m);
`ifdef MAX_POOL_RELU_EN
    if (m[DATA_W-1]) begin
      return '0;
    end else begin
      return m;
    end
`else
    return m;
`endif
  endfunction

  // kc/win are col split into (col % K, col / K) so no divider is needed for K=3.
  logic [CW-1:0] col_q, col_d;
  logic [KW-1:0] kc_q,  kc_d;
  logic [WW-1:0] win_q, win_d;
  logic [KW-1:0] kr_q,  kr_d;
  logic [RW-1:0] row_q, row_d;

  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic              out_last_q,   out_last_d;
  logic              frame_done_q, frame_done_d;

  sample_t buf_q [NWIN];

  logic    in_ready_s;
  logic    in_xfer_s;
  logic    out_xfer_s;
  logic    first_s;
  logic    last_s;
  logic    frame_last_s;
  sample_t cur_max_s;

  assign in_ready_s     = !out_valid_q || bus.out_ready;
  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;

  // Handshake decode and window-position qualifiers for the sample on the bus.
  always_comb begin
    in_xfer_s    = bus.in_valid && in_ready_s;
    out_xfer_s   = out_valid_q && bus.out_ready;
    first_s      = (kr_q == '0) && (kc_q == '0);
    last_s       = (kr_q == K_LAST) && (kc_q == K_LAST);
    frame_last_s = (row_q == ROW_LAST) && (win_q == WIN_LAST);
    if (first_s) begin
      cur_max_s = sample_t'(bus.in_data);
    end else begin
      cur_max_s = smax(buf_q[win_q], sample_t'(bus.in_data));
    end
  end

  // Raster position: col -> kr -> row -> frame, stepping only on accepted samples.
  always_comb begin
    col_d = col_q;
    kc_d  = kc_q;
    win_d = win_q;
    kr_d  = kr_q;
    row_d = row_q;
    if (in_xfer_s) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        kc_d  = '0;
        win_d = '0;
        if (kr_q == K_LAST) begin
          kr_d = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          kr_d  = kr_q + KW'(1);
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        if (kc_q == K_LAST) begin
          kc_d  = '0;
          win_d = win_q + WW'(1);
        end else begin
          kc_d  = kc_q + KW'(1);
          win_d = win_q;
        end
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Output register: a completing window reloads it even while the old value leaves.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = out_xfer_s && out_last_q;
    if (in_xfer_s && last_s) begin
      out_valid_d = 1'b1;
      out_data_d  = finalize(cur_max_s);
      out_last_d  = frame_last_s;
    end else if (out_xfer_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
    end
  end

  // Control and output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      kc_q         <= '0;
      win_q        <= '0;
      kr_q         <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      kc_q         <= kc_d;
      win_q        <= win_d;
      kr_q         <= kr_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Partial maxima need no reset: the first sample of every window overwrites its entry.
  always_ff @(posedge clk) begin
    if (in_xfer_s) begin
      buf_q[win_q] <= cur_max_s;
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// Scoreboard bench for max_pool_stream at K=2, IMG_W=4, IMG_H=2, DATA_W=16.
// Expected maxima follow MAX_POOL_RELU_EN when the bench is built with it.
module tb_max_pool_stream;
  localparam int DW = 16;
  localparam int KP = 2;
  localparam int WP = 4;
  localparam int HP = 2;
  localparam int NPIX = WP * HP;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  max_pool_stream_if #(.DATA_W(DW)) bus ();

  max_pool_stream #(.DATA_W(DW), .K(KP), .IMG_W(WP), .IMG_H(HP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          fd_cnt   = 0;
  int          out_cnt  = 0;
  logic        mon_en   = 1'b0;
  logic        fd_exp   = 1'b0;
  logic [15:0] frm [NPIX];

  function automatic logic [15:0] ref_pool(input int band, input int w);
    logic signed [15:0] m;
    logic signed [15:0] v;
    m = frm[band * KP * WP + w * KP];
    for (int r = 0; r < KP; r++) begin
      for (int c = 0; c < KP; c++) begin
        v = frm[(band * KP + r) * WP + w * KP + c];
        if (v > m) m = v;
      end
    end
`ifdef MAX_POOL_RELU_EN
    if (m < 16'sd0) m = 16'sd0;
`endif
    return m;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int b = 0; b < HP / KP; b++) begin
      for (int w = 0; w < WP / KP; w++) begin
        e.data = ref_pool(b, w);
        e.last = (b == HP / KP - 1) && (w == WP / KP - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic load_ref_frame();
    frm[0] = 16'hE003; frm[1] = 16'hFFFF; frm[2] = 16'h0001; frm[3] = 16'h0004;
    frm[4] = 16'hFFFE; frm[5] = 16'hFFFC; frm[6] = 16'h0003; frm[7] = 16'hFFFE;
  endtask

  // Output monitor: pops the scoreboard on each output transfer, checks frame_done a cycle later.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fd_exp || bus.frame_done) begin
        n_checks++;
        if (bus.frame_done !== fd_exp)
          $display("FAIL frame_done: got %b expected %b", bus.frame_done, fd_exp);
        else
          n_pass++;
      end
      if (bus.frame_done === 1'b1) fd_cnt++;
      fd_exp = 1'b0;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        out_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_unexpected: got %h expected no output", bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.out_data !== mon_e.data)
            $display("FAIL out_data: got %h expected %h", bus.out_data, mon_e.data);
          else
            n_pass++;
          fd_exp = mon_e.last;
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, output int waits);
    logic acc;
    logic done;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc === 1'b1) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 200) begin
          n_checks++;
          $display("FAIL send_timeout: got no acceptance after %0d cycles expected acceptance", waits);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_range(input int lo, input int hi, output int stalls);
    int w;
    stalls = 0;
    for (int i = lo; i < hi; i++) begin
      send(frm[i], w);
      stalls += w;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || fd_exp) && n < 100) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (n >= 100)
      $display("FAIL drain_timeout: got %0d outputs pending expected 0", exp_q.size());
    else
      n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name, input int d_out, input int e_out,
                              input int d_fd, input int e_fd);
    n_checks++;
    if (d_out !== e_out) $display("FAIL %s_outputs: got %0d expected %0d", name, d_out, e_out);
    else n_pass++;
    n_checks++;
    if (d_fd !== e_fd) $display("FAIL %s_frame_done_count: got %0d expected %0d", name, d_fd, e_fd);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.out_data !== 16'h0000 ||
        bus.in_ready !== 1'b1)
      $display("FAIL reset_outputs: got valid=%b fd=%b data=%h rdy=%b expected 0 0 0000 1",
               bus.out_valid, bus.frame_done, bus.out_data, bus.in_ready);
    else
      n_pass++;
    n_checks++;
    if (dut.col_q !== 2'd0 || dut.kr_q !== 1'd0 || dut.row_q !== 1'd0)
      $display("FAIL reset_counters: got col=%0d kr=%0d row=%0d expected 0 0 0",
               dut.col_q, dut.kr_q, dut.row_q);
    else
      n_pass++;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int st, o0, f0;
    o0 = out_cnt; f0 = fd_cnt;
    load_ref_frame();
    push_frame();
    send_range(0, NPIX, st);
    bus.in_valid = 1'b0;
    drain();
    check_counts("basic", out_cnt - o0, 2, fd_cnt - f0, 1);
    n_checks++;
    if (st !== 0) $display("FAIL basic_stalls: got %0d expected 0", st);
    else n_pass++;
  endtask

  task automatic test_min_value();
    int st, o0, f0;
    o0 = out_cnt; f0 = fd_cnt;
    for (int i = 0; i < NPIX; i++) frm[i] = 16'h8000;
    push_frame();
    send_range(0, NPIX, st);
    bus.in_valid = 1'b0;
    drain();
    check_counts("min_value", out_cnt - o0, 2, fd_cnt - f0, 1);
  endtask

  task automatic test_stall();
    int st, w;
    logic [15:0] e0;
    load_ref_frame();
    push_frame();
    e0 = ref_pool(0, 0);
    bus.out_ready = 1'b0;
    send_range(0, 6, st);
    bus.in_valid = 1'b1;
    bus.in_data  = frm[6];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== e0)
        $display("FAIL stall_hold: got rdy=%b valid=%b data=%h expected 0 1 %h",
                 bus.in_ready, bus.out_valid, bus.out_data, e0);
      else
        n_pass++;
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(frm[6], w);
    send(frm[7], w);
    bus.in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_frame();
    int st, o0, f0;
    load_ref_frame();
    push_frame();
    bus.out_ready = 1'b0;
    send_range(0, 6, st);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL midrst_pending: got %b expected 1", bus.out_valid);
    else n_pass++;
    mon_en = 1'b0;
    exp_q.delete();
    fd_exp = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.in_ready !== 1'b1)
      $display("FAIL midrst_async: got valid=%b data=%h rdy=%b expected 0 0000 1",
               bus.out_valid, bus.out_data, bus.in_ready);
    else
      n_pass++;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    mon_en        = 1'b1;
    o0 = out_cnt; f0 = fd_cnt;
    push_frame();
    send_range(0, NPIX, st);
    bus.in_valid = 1'b0;
    drain();
    check_counts("midrst", out_cnt - o0, 2, fd_cnt - f0, 1);
  endtask

  task automatic test_back_to_back();
    int st_a, st_b, o0, f0;
    o0 = out_cnt; f0 = fd_cnt;
    load_ref_frame();
    push_frame();
    send_range(0, NPIX, st_a);
    for (int i = 0; i < NPIX; i++) frm[i] = 16'($urandom);
    push_frame();
    send_range(0, NPIX, st_b);
    bus.in_valid = 1'b0;
    drain();
    check_counts("b2b", out_cnt - o0, 4, fd_cnt - f0, 2);
    n_checks++;
    if (st_a + st_b !== 0) $display("FAIL b2b_stalls: got %0d expected 0", st_a + st_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_value();
    test_stall();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end
endmodule
